// File: rtl/store_router.sv
// store_router: store-side address decoder and write router for the data bus.
// Data-memory stores are registered and forwarded in one cycle, output-window
// stores are queued in a first-word-fall-through FIFO and drained over a
// valid/ready handshake, and every other address is dropped and flagged.
module store_router #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned OUT_BASE   = 1040,
  parameter int unsigned OUT_WORDS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [1:0]  out_sel,
  input  logic        out_ready,
  output logic        store_fault
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0]     MemTop   = 32'(MEM_WORDS);
  localparam logic [31:0]     OutLo    = 32'(OUT_BASE);
  localparam logic [31:0]     OutHi    = 32'(OUT_BASE + OUT_WORDS);
  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);

  // Address decode and handshake qualifiers
  logic memHit;
  logic outHit;
  logic faultHit;
  logic fifoFull;
  logic fifoEmpty;
  logic accept;
  logic doPush;
  logic doPop;
  logic [1:0] pushSel;

  // FIFO storage and bookkeeping
  logic [31:0]     fifoData [FIFO_DEPTH];
  logic [1:0]      fifoSel  [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [CntW-1:0] count;

  // Decode the store address and derive stall/push/pop for this cycle
  always_comb begin
    memHit    = (address < MemTop);
    outHit    = (address >= OutLo) && (address < OutHi);
    faultHit  = !memHit && !outHit;
    fifoFull  = (count == FullCnt);
    fifoEmpty = (count == '0);
    // stall looks only at occupancy, so a pop in the same cycle never
    // opens a slot for the stalled store
    stall     = store_en && outHit && fifoFull;
    accept    = store_en && !stall;
    doPush    = accept && outHit;
    doPop     = !fifoEmpty && out_ready;
    pushSel   = address[1:0] - OutLo[1:0];
  end

  // Head of queue is shown straight from storage
  always_comb begin
    out_valid = !fifoEmpty;
    out_data  = fifoData[rdPtr];
    out_sel   = fifoSel[rdPtr];
  end

  // Memory write port: one-cycle registered forward of accepted memory stores
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept && memHit;
      if (accept && memHit) begin
        mem_addr  <= address[9:0];
        mem_wdata <= write_data;
      end
    end
  end

  // Fault flag: one-cycle pulse for a store that hits no window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_fault <= 1'b0;
    end else begin
      store_fault <= store_en && faultHit;
    end
  end

  // FIFO storage: cleared on reset so the idle head reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifoData[i] <= '0;
        fifoSel[i]  <= '0;
      end
    end else if (doPush) begin
      fifoData[wrPtr] <= write_data;
      fifoSel[wrPtr]  <= pushSel;
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo the depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_router.sv
// tb_store_router: directed-vector bench for store_router with hand-computed
// expected values.
module tb_store_router;

  logic        clk;
  logic        rst;
  logic        store_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        stall;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic        store_fault;

  int checks = 0;
  int errors = 0;

  store_router #(
    .MEM_WORDS (1024),
    .OUT_BASE  (1040),
    .OUT_WORDS (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .store_en   (store_en),
    .address    (address),
    .write_data (write_data),
    .stall      (stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_ready  (out_ready),
    .store_fault(store_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setStore(input logic [31:0] a, input logic [31:0] d);
    store_en   = 1'b1;
    address    = a;
    write_data = d;
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    checkVal({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      checkVal({tag, ".sel"}, 32'(out_sel), 32'(s));
      checkVal({tag, ".data"}, out_data, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] faultAddrs [4];
    faultAddrs = '{32'd1024, 32'd1036, 32'd1039, 32'd1044};

    rst = 1'b1; store_en = 1'b0; address = '0; write_data = '0; out_ready = 1'b0;
    #12;
    // Reset state
    checkVal("rst.mem_we", 32'(mem_we), 0);
    checkVal("rst.mem_addr", 32'(mem_addr), 0);
    checkVal("rst.mem_wdata", mem_wdata, 0);
    checkVal("rst.store_fault", 32'(store_fault), 0);
    checkVal("rst.out_valid", 32'(out_valid), 0);
    checkVal("rst.out_sel", 32'(out_sel), 0);
    checkVal("rst.out_data", out_data, 0);
    checkVal("rst.stall", 32'(stall), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Single memory store
    setStore(32'd5, 32'hDEADBEEF);
    #1 checkVal("mem5.stall", 32'(stall), 0);
    cyc();
    store_en = 1'b0;
    checkVal("mem5.we", 32'(mem_we), 1);
    checkVal("mem5.addr", 32'(mem_addr), 5);
    checkVal("mem5.wdata", mem_wdata, 32'hDEADBEEF);
    checkVal("mem5.fault", 32'(store_fault), 0);
    cyc();
    checkVal("mem5.we_off", 32'(mem_we), 0);
    checkVal("mem5.addr_hold", 32'(mem_addr), 5);
    checkVal("mem5.stall_off", 32'(stall), 0);

    // Top of memory window
    setStore(32'd1023, 32'h11);
    cyc();
    store_en = 1'b0;
    checkVal("mem1023.we", 32'(mem_we), 1);
    checkVal("mem1023.addr", 32'(mem_addr), 32'h3FF);
    checkVal("mem1023.valid", 32'(out_valid), 0);
    cyc();

    // Unmapped addresses: fault pulse only
    foreach (faultAddrs[k]) begin
      setStore(faultAddrs[k], 32'h55);
      #1 checkVal("fault.stall", 32'(stall), 0);
      cyc();
      store_en = 1'b0;
      checkVal("fault.pulse", 32'(store_fault), 1);
      checkVal("fault.mem_we", 32'(mem_we), 0);
      checkVal("fault.valid", 32'(out_valid), 0);
      cyc();
      checkVal("fault.pulse_off", 32'(store_fault), 0);
      checkVal("fault.addr_hold", 32'(mem_addr), 32'h3FF);
    end

    // Output window edges
    setStore(32'd1040, 32'hA0);
    cyc();
    store_en = 1'b0;
    checkHead("out1040", 1'b1, 2'd0, 32'hA0);
    checkVal("out1040.mem_we", 32'(mem_we), 0);
    checkVal("out1040.fault", 32'(store_fault), 0);
    out_ready = 1'b1;
    cyc();
    checkHead("out1040.pop", 1'b0, 2'd0, 32'h0);
    out_ready = 1'b0;
    setStore(32'd1043, 32'hA3);
    cyc();
    store_en = 1'b0;
    checkHead("out1043", 1'b1, 2'd3, 32'hA3);
    out_ready = 1'b1;
    cyc();
    checkHead("out1043.pop", 1'b0, 2'd0, 32'h0);
    out_ready = 1'b0;

    // Fill with out_ready low
    for (int i = 0; i < 4; i++) begin
      setStore(32'd1040 + 32'(i), 32'(i + 1));
      #1 checkVal("fill.stall", 32'(stall), 0);
      cyc();
    end
    store_en = 1'b0;
    checkHead("full.head", 1'b1, 2'd0, 32'd1);
    setStore(32'd1041, 32'h5);
    for (int i = 0; i < 3; i++) begin
      #1 checkVal("full.stall_held", 32'(stall), 1);
      cyc();
      checkHead("full.head_held", 1'b1, 2'd0, 32'd1);
      checkVal("full.mem_we", 32'(mem_we), 0);
    end

    // Drain with the fifth store still pending
    out_ready = 1'b1;
    #1 checkVal("drain.stall_pop_cycle", 32'(stall), 1);
    cyc();
    checkVal("drain.stall_clear", 32'(stall), 0);
    checkHead("drain.e1", 1'b1, 2'd1, 32'd2);
    cyc();
    store_en = 1'b0;
    checkHead("drain.e2", 1'b1, 2'd2, 32'd3);
    cyc();
    checkHead("drain.e3", 1'b1, 2'd3, 32'd4);
    cyc();
    checkHead("drain.e4", 1'b1, 2'd1, 32'd5);
    cyc();
    checkHead("drain.empty", 1'b0, 2'd0, 32'h0);

    // Steady push/pop at occupancy 2 across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setStore(32'd1040 + 32'(i), 32'h100 + 32'(i));
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      setStore(32'd1040 + 32'(i % 4), 32'h100 + 32'(i));
      #1 checkVal("stream.stall", 32'(stall), 0);
      cyc();
      checkHead("stream.head", 1'b1, 2'((i - 1) % 4), 32'h100 + 32'(i - 1));
    end
    store_en = 1'b0;
    cyc();
    checkHead("stream.tail10", 1'b1, 2'd3, 32'h10B);
    cyc();
    checkHead("stream.tail_empty", 1'b0, 2'd0, 32'h0);
    out_ready = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      setStore(32'd1040 + 32'(i), 32'h31 + 32'(i));
      cyc();
    end
    setStore(32'd7, 32'hCAFE);
    cyc();
    store_en = 1'b0;
    checkVal("pre_rst.mem_we", 32'(mem_we), 1);
    checkHead("pre_rst.head", 1'b1, 2'd0, 32'h31);
    #2 rst = 1'b1;
    #1;
    checkVal("arst.mem_we", 32'(mem_we), 0);
    checkVal("arst.mem_addr", 32'(mem_addr), 0);
    checkVal("arst.mem_wdata", mem_wdata, 0);
    checkVal("arst.store_fault", 32'(store_fault), 0);
    checkVal("arst.out_valid", 32'(out_valid), 0);
    checkVal("arst.out_sel", 32'(out_sel), 0);
    checkVal("arst.out_data", out_data, 0);
    checkVal("arst.stall", 32'(stall), 0);
    cyc();
    rst = 1'b0;
    cyc();
    setStore(32'd1042, 32'h77);
    cyc();
    store_en = 1'b0;
    checkHead("post_rst.head", 1'b1, 2'd2, 32'h77);
    out_ready = 1'b1;
    cyc();
    checkHead("post_rst.empty", 1'b0, 2'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
